// File: rtl/montgomery_mul_pipe.sv
// montgomery_mul_pipe: 3-stage elastic multi-lane Montgomery multiply/reduce (q=3329, R=2^16) with tag sideband
module montgomery_mul_pipe #(
  parameter int LANES   = 2,
  parameter int COEFF_W = 16,
  parameter int TAG_W   = 8,
  parameter int QINV    = 62209,
  parameter int KYBER_Q = 3329,
  parameter int MONT_R2 = 1353
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [LANES*COEFF_W-1:0]   in_a,
  input  logic [LANES*COEFF_W-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_W-1:0]           out_tag,
  output logic [LANES*COEFF_W-1:0]   out_coeffs
);
  localparam int PW = 2 * COEFF_W;
  logic v1, v2, v3, en1, en2, en3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [LANES-1:0][PW-1:0] p1, p2, p_n;
  logic [LANES-1:0][COEFF_W-1:0] u2, r3, u_n, r_n;
  // a stage may load whenever it is empty or its contents move on this cycle
  assign en3 = !v3 || out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;
  assign in_ready = en1;
  assign out_valid = v3;
  assign out_tag = tag3;
  assign out_coeffs = r3;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] ae, be, t;
    // sign-extended operands; the low PW bits of an unsigned product equal the signed product
    assign ae = PW'($signed(in_a[i*COEFF_W +: COEFF_W]));
    assign be = in_mode ? PW'(MONT_R2) : PW'($signed(in_b[i*COEFF_W +: COEFF_W]));
    assign p_n[i] = ae * be;
    assign u_n[i] = p1[i][COEFF_W-1:0] * COEFF_W'(QINV);
    assign t = PW'($signed(u2[i])) * PW'(KYBER_Q);
    assign r_n[i] = COEFF_W'((p2[i] - t) >> COEFF_W);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      p1 <= '0;
      p2 <= '0;
      u2 <= '0;
      r3 <= '0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en1 && in_valid) begin
        p1 <= p_n;
        tag1 <= in_tag;
      end
      if (en2 && v1) begin
        p2 <= p1;
        u2 <= u_n;
        tag2 <= tag1;
      end
      if (en3 && v2) begin
        r3 <= r_n;
        tag3 <= tag2;
      end
    end
  end
endmodule
